stream_mac: RTL and testbench

Downstream consumer of the address/data streamer: takes the sample stream it produces (one signed DWIDTH-bit sample per enabled cycle), multiplies each sample by a paired signed coefficient, and accumulates a programmable number of products into one saturating dot-product result. The result is presented on a valid/ready output port for the next layer stage. This is the basic MAC primitive for the fully connected and convolution datapaths.

---
 rtl/stream_mac_if.sv | 33 +++
 rtl/stream_mac.sv | 181 ++++++++++++++++++
 tb/tb_stream_mac.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mac_if.sv
// stream_mac_if
//   Bundles the job-control, input-beat and result handshake signals of the
//   stream_mac block.
//   master : job issuer / upstream streamer / downstream consumer side
//            (drives start, length, ivalid, dataa, datab, oready)
//   slave  : the MAC itself
//            (drives iready, ovalid, result, busy, overflow)
interface stream_mac_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 32
);
   logic                     start;
   logic [31:0]              length;
   logic                     ivalid;
   logic                     iready;
   logic signed [DWIDTH-1:0] dataa;
   logic signed [DWIDTH-1:0] datab;
   logic                     ovalid;
   logic                     oready;
   logic signed [AWIDTH-1:0] result;
   logic                     busy;
   logic                     overflow;

   modport master (
      output start, length, ivalid, dataa, datab, oready,
      input  iready, ovalid, result, busy, overflow
   );

   modport slave (
      input  start, length, ivalid, dataa, datab, oready,
      output iready, ovalid, result, busy, overflow
   );
endinterface

// File: rtl/stream_mac.sv
// stream_mac
//   Saturating multiply-accumulate over a programmable number of signed
//   sample/coefficient pairs.  A START pulse in IDLE latches the job length;
//   beats are multiplied into a product register (stage 1) and summed into
//   a saturating accumulator one edge later (stage 2).  The final sum is
//   offered on a valid/ready result port.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state
//   s     : stream_mac_if slave port (start/length, ivalid/iready/dataa/datab,
//           ovalid/oready/result, busy, overflow)
module stream_mac #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   stream_mac_if.slave  s
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACC   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   state_e                     state_q, state_d;
   logic [31:0]                len_q, len_d;
   logic [31:0]                cnt_q, cnt_d;
   logic signed [2*DWIDTH-1:0] prod_q, prod_d;
   logic                       prod_vld_q, prod_vld_d;
   logic signed [AWIDTH-1:0]   acc_q, acc_d;
   logic                       ovf_q, ovf_d;
   logic [AWIDTH:0]            sat_s;

   // Returns {clamped, value}: acc + sign-extended prod evaluated one bit
   // wider than the accumulator, clamped to the signed AWIDTH range.
   function automatic logic [AWIDTH:0] sat_add(
      input logic signed [AWIDTH-1:0]   acc,
      input logic signed [2*DWIDTH-1:0] prod
   );
      logic signed [AWIDTH:0] sum;
      sum = (AWIDTH+1)'(acc) + (AWIDTH+1)'(prod);
      // The two top bits disagree only when the true sum left the AWIDTH range.
      if (sum[AWIDTH] != sum[AWIDTH-1]) begin
         if (sum[AWIDTH]) begin
            sat_add = {1'b1, 1'b1, {(AWIDTH-1){1'b0}}};
         end else begin
            sat_add = {1'b1, 1'b0, {(AWIDTH-1){1'b1}}};
         end
      end else begin
         sat_add = {1'b0, sum[AWIDTH-1:0]};
      end
   endfunction

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= 32'd0;
         cnt_q      <= 32'd0;
         prod_q     <= '0;
         prod_vld_q <= 1'b0;
         acc_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         prod_q     <= prod_d;
         prod_vld_q <= prod_vld_d;
         acc_q      <= acc_d;
         ovf_q      <= ovf_d;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      prod_d     = prod_q;
      prod_vld_d = prod_vld_q;
      acc_d      = acc_q;
      ovf_d      = ovf_q;
      sat_s      = sat_add(acc_q, prod_q);
      case (state_q)
         ST_IDLE: begin
            if (s.start) begin
               len_d      = s.length;
               cnt_d      = 32'd0;
               acc_d      = '0;
               ovf_d      = 1'b0;
               prod_vld_d = 1'b0;
               if (s.length == 32'd0) begin
                  state_d = ST_OUT;
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            // Stage 2 consumes the product captured on the previous edge.
            if (prod_vld_q) begin
               acc_d = sat_s[AWIDTH-1:0];
               ovf_d = ovf_q | sat_s[AWIDTH];
            end else begin
               acc_d = acc_q;
            end
            if (s.ivalid) begin
               prod_d     = (2*DWIDTH)'(s.dataa) * (2*DWIDTH)'(s.datab);
               prod_vld_d = 1'b1;
               cnt_d      = cnt_q + 32'd1;
               if (cnt_q == len_q - 32'd1) begin
                  state_d = ST_FLUSH;
               end else begin
                  state_d = ST_ACC;
               end
            end else begin
               prod_vld_d = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (prod_vld_q) begin
               acc_d = sat_s[AWIDTH-1:0];
               ovf_d = ovf_q | sat_s[AWIDTH];
            end else begin
               acc_d = acc_q;
            end
            prod_vld_d = 1'b0;
            state_d    = ST_OUT;
         end
         ST_OUT: begin
            if (s.oready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_OUT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Port outputs: handshake flags decode the state register only.
   always_comb begin
      s.result   = acc_q;
      s.overflow = ovf_q;
      case (state_q)
         ST_IDLE: begin
            s.iready = 1'b0;
            s.ovalid = 1'b0;
            s.busy   = 1'b0;
         end
         ST_ACC: begin
            s.iready = 1'b1;
            s.ovalid = 1'b0;
            s.busy   = 1'b1;
         end
         ST_FLUSH: begin
            s.iready = 1'b0;
            s.ovalid = 1'b0;
            s.busy   = 1'b1;
         end
         ST_OUT: begin
            s.iready = 1'b0;
            s.ovalid = 1'b1;
            s.busy   = 1'b1;
         end
         default: begin
            s.iready = 1'b0;
            s.ovalid = 1'b0;
            s.busy   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_stream_mac.sv
// tb_stream_mac
//   Drives identical jobs into a 32-bit and a 16-bit accumulator instance
//   and compares results, overflow and handshake timing against a
//   clamped-running-sum reference computed from the pair lists.
module tb_stream_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic              start_s;
   logic [31:0]       length_s;
   logic              ivalid_s;
   logic signed [7:0] dataa_s;
   logic signed [7:0] datab_s;
   logic              oready_s;

   stream_mac_if #(.DWIDTH(8), .AWIDTH(32)) if32 ();
   stream_mac_if #(.DWIDTH(8), .AWIDTH(16)) if16 ();

   assign if32.start  = start_s;
   assign if32.length = length_s;
   assign if32.ivalid = ivalid_s;
   assign if32.dataa  = dataa_s;
   assign if32.datab  = datab_s;
   assign if32.oready = oready_s;
   assign if16.start  = start_s;
   assign if16.length = length_s;
   assign if16.ivalid = ivalid_s;
   assign if16.dataa  = dataa_s;
   assign if16.datab  = datab_s;
   assign if16.oready = oready_s;

   stream_mac #(.DWIDTH(8), .AWIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .s(if32));
   stream_mac #(.DWIDTH(8), .AWIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .s(if16));

   int checks   = 0;
   int failures = 0;
   int qa[$];
   int qb[$];
   int bub[$];

   // Single comparison point for the whole bench.
   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: running sum of products, clamped to the aw-bit signed range
   // after every product.
   function automatic void model(input int aw, output longint res, output bit ovf);
      longint mx;
      longint mn;
      mx  = (longint'(1) <<< (aw - 1)) - 64'sd1;
      mn  = -mx - 64'sd1;
      res = 0;
      ovf = 1'b0;
      foreach (qa[i]) begin
         res += longint'(qa[i] * qb[i]);
         if (res > mx) begin
            res = mx;
            ovf = 1'b1;
         end else if (res < mn) begin
            res = mn;
            ovf = 1'b1;
         end
      end
   endfunction

   task automatic check_idle_zero(input string tag);
      check_eq({tag, "_iready32"}, if32.iready, 0);
      check_eq({tag, "_ovalid32"}, if32.ovalid, 0);
      check_eq({tag, "_busy32"}, if32.busy, 0);
      check_eq({tag, "_ovf32"}, if32.overflow, 0);
      check_eq({tag, "_res32"}, $signed(if32.result), 0);
      check_eq({tag, "_ovf16"}, if16.overflow, 0);
      check_eq({tag, "_res16"}, $signed(if16.result), 0);
      check_eq({tag, "_busy16"}, if16.busy, 0);
   endtask

   // Runs the job described by qa/qb. Bubbles before beat i come from bub
   // when present, otherwise random up to bubble_max.
   task automatic run_job(input string tag, input int bubble_max, input int hold,
                          input bit poke_start);
      int     len;
      int     nb;
      longint e32;
      longint e16;
      bit     o32;
      bit     o16;
      logic signed [63:0] held32;
      logic signed [63:0] held16;
      len = qa.size();
      model(32, e32, o32);
      model(16, e16, o16);
      @(negedge clk);
      start_s  = 1'b1;
      length_s = 32'(len);
      @(negedge clk);
      start_s  = 1'b0;
      length_s = $urandom;
      if (len != 0) begin
         check_eq({tag, "_acc_iready"}, if32.iready, 1);
         check_eq({tag, "_acc_busy"}, if32.busy, 1);
         for (int i = 0; i < len; i++) begin
            nb = (bub.size() > i) ? bub[i] : int'($urandom_range(0, bubble_max));
            for (int j = 0; j < nb; j++) begin
               ivalid_s = 1'b0;
               dataa_s  = 8'($urandom);
               datab_s  = 8'($urandom);
               @(negedge clk);
            end
            ivalid_s = 1'b1;
            dataa_s  = 8'(qa[i]);
            datab_s  = 8'(qb[i]);
            if (poke_start && i == 0) begin
               start_s  = 1'b1;
               length_s = 32'd1;
            end
            @(negedge clk);
            start_s  = 1'b0;
            ivalid_s = 1'b0;
            if (i < len - 1) begin
               check_eq({tag, "_still_acc"}, if32.iready, 1);
            end
         end
         check_eq({tag, "_flush_iready"}, if32.iready, 0);
         check_eq({tag, "_flush_ovalid"}, if32.ovalid, 0);
         check_eq({tag, "_flush_busy"}, if16.busy, 1);
         @(negedge clk);
      end
      check_eq({tag, "_ovalid32"}, if32.ovalid, 1);
      check_eq({tag, "_ovalid16"}, if16.ovalid, 1);
      check_eq({tag, "_res32"}, $signed(if32.result), e32);
      check_eq({tag, "_res16"}, $signed(if16.result), e16);
      check_eq({tag, "_ovf32"}, if32.overflow, 64'(o32));
      check_eq({tag, "_ovf16"}, if16.overflow, 64'(o16));
      held32 = $signed(if32.result);
      held16 = $signed(if16.result);
      for (int h = 0; h < hold; h++) begin
         oready_s = 1'b0;
         @(negedge clk);
         check_eq({tag, "_hold_ovalid"}, if32.ovalid, 1);
         check_eq({tag, "_hold_res32"}, $signed(if32.result), held32);
         check_eq({tag, "_hold_res16"}, $signed(if16.result), held16);
      end
      // A START coinciding with the output handshake must be ignored.
      oready_s = 1'b1;
      start_s  = 1'b1;
      length_s = 32'd3;
      @(negedge clk);
      oready_s = 1'b0;
      start_s  = 1'b0;
      check_eq({tag, "_done_ovalid"}, if32.ovalid, 0);
      check_eq({tag, "_done_busy32"}, if32.busy, 0);
      check_eq({tag, "_done_busy16"}, if16.busy, 0);
      bub.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      start_s  = 1'b0;
      length_s = 32'd0;
      ivalid_s = 1'b0;
      dataa_s  = 8'sd0;
      datab_s  = 8'sd0;
      oready_s = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_zero("reset");
      rst_n = 1'b1;

      // Basic back-to-back job.
      qa = '{1, 3, -5, 7};
      qb = '{2, 4, 6, -8};
      bub = '{0, 0, 0, 0};
      run_job("basic", 0, 0, 1'b0);

      // Bubbles (ivalid 1,0,0,1,0,1) and 5 cycles of backpressure.
      qa = '{10, -3, 2};
      qb = '{10, 7, -1};
      bub = '{0, 2, 1};
      run_job("bubble", 0, 5, 1'b0);

      // Saturates the 16-bit instance only.
      qa = '{127, 127, 127, 127};
      qb = '{127, 127, 127, 127};
      run_job("sat_pos", 1, 1, 1'b0);
      qa = '{1};
      qb = '{1};
      run_job("sat_clear", 1, 0, 1'b0);
      qa = '{-128, -128, -128, 127};
      qb = '{127, 127, 127, 127};
      run_job("sat_neg", 1, 0, 1'b0);

      // Zero length, then a START poked during ACC of a 2-beat job.
      qa.delete();
      qb.delete();
      run_job("len0", 0, 1, 1'b0);
      qa = '{-7, 9};
      qb = '{11, 13};
      run_job("poke", 2, 0, 1'b1);

      // Reset mid-job after 3 beats, with the 16-bit overflow already set.
      @(negedge clk);
      start_s  = 1'b1;
      length_s = 32'd8;
      @(negedge clk);
      start_s = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ivalid_s = 1'b1;
         dataa_s  = 8'sd127;
         datab_s  = 8'sd127;
         @(negedge clk);
      end
      ivalid_s = 1'b0;
      @(negedge clk);
      check_eq("pre_rst_busy", if32.busy, 1);
      check_eq("pre_rst_ovf16", if16.overflow, 1);
      rst_n = 1'b0;
      #1;
      check_idle_zero("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      qa = '{-128};
      qb = '{-128};
      run_job("after_rst", 0, 0, 1'b0);

      // Randomized jobs.
      for (int t = 0; t < 14; t++) begin
         int len;
         len = int'($urandom_range(0, 12));
         qa.delete();
         qb.delete();
         for (int i = 0; i < len; i++) begin
            qa.push_back(int'($signed(8'($urandom))));
            qb.push_back(int'($signed(8'($urandom))));
         end
         run_job("rand", 2, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
